mem_port_arbiter: RTL and testbench

//  Shares one single-port data/instruction memory between the fetch stage (IF, read-only) and the

---
 rtl/mem_port_arbiter_pkg.sv | 12 +
 rtl/mem_arb_watchdog.sv | 25 ++
 rtl/mem_port_arbiter.sv | 129 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the IF/MEM memory port arbiter.
package mem_port_arbiter_pkg;

    localparam int XLEN_DEF = 32;

    typedef enum logic [1:0] {
        ARB_IDLE     = 2'd0,
        ARB_BUSY_IF  = 2'd1,
        ARB_BUSY_MEM = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arb_watchdog.sv
// Cycle counter for a busy memory transaction; flags expiry on the TIMEOUT-th busy cycle.
module mem_arb_watchdog #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;

    // Dropping run (back in IDLE) clears the count for the next transaction.
    always_ff @(posedge clk) begin
        if (rst || !run)
            cnt <= '0;
        else if (!expired)
            cnt <= cnt + 1'b1;
    end

    assign expired = run && (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch (IF) and load/store (MEM), one transaction at a time.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int XLEN           = XLEN_DEF,
    parameter int MAX_MEM_STREAK = 4,
    parameter int TIMEOUT        = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    output logic [XLEN-1:0] if_rdata,
    output logic            if_rvalid,
    output logic            if_stall,
    input  logic            flush,
    input  logic            mem_req,
    input  logic            mem_we,
    input  logic [3:0]      mem_be,
    input  logic [XLEN-1:0] mem_addr,
    input  logic [XLEN-1:0] mem_wdata,
    output logic [XLEN-1:0] mem_rdata,
    output logic            mem_done,
    output logic            mem_stall,
    output logic            mp_req,
    output logic            mp_we,
    output logic [3:0]      mp_be,
    output logic [XLEN-1:0] mp_addr,
    output logic [XLEN-1:0] mp_wdata,
    input  logic            mp_ack,
    input  logic [XLEN-1:0] mp_rdata,
    output logic            timeout_err
);

    localparam int SW = $clog2(MAX_MEM_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_MEM_STREAK);

    arb_state_t    state;
    logic [SW-1:0] streak;
    logic          fetch_flushed;
    logic          wd_expired;

    mem_arb_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .run     (state != ARB_IDLE),
        .expired (wd_expired)
    );

    assign if_stall  = if_req  & ~if_rvalid;
    assign mem_stall = mem_req & ~mem_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ARB_IDLE;
            streak        <= '0;
            fetch_flushed <= 1'b0;
            mp_req        <= 1'b0;
            mp_we         <= 1'b0;
            mp_be         <= '0;
            mp_addr       <= '0;
            mp_wdata      <= '0;
            if_rdata      <= '0;
            mem_rdata     <= '0;
            if_rvalid     <= 1'b0;
            mem_done      <= 1'b0;
            timeout_err   <= 1'b0;
        end else begin
            if_rvalid   <= 1'b0;
            mem_done    <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    fetch_flushed <= 1'b0;
                    // MEM wins unless IF has waited through a full streak of MEM grants.
                    if (mem_req && (!if_req || streak < STREAK_MAX)) begin
                        state    <= ARB_BUSY_MEM;
                        mp_req   <= 1'b1;
                        mp_we    <= mem_we;
                        mp_be    <= mem_be;
                        mp_addr  <= mem_addr;
                        mp_wdata <= mem_wdata;
                        streak   <= if_req ? streak + 1'b1 : '0;
                    end else if (if_req && !flush) begin
                        state    <= ARB_BUSY_IF;
                        mp_req   <= 1'b1;
                        mp_we    <= 1'b0;
                        mp_be    <= 4'hF;
                        mp_addr  <= if_addr;
                        mp_wdata <= '0;
                        streak   <= '0;
                    end
                end
                ARB_BUSY_IF: begin
                    if (flush)
                        fetch_flushed <= 1'b1;
                    if (mp_ack) begin
                        mp_req <= 1'b0;
                        state  <= ARB_IDLE;
                        // A flushed fetch still completes on the port but is never delivered.
                        if (!(flush || fetch_flushed)) begin
                            if_rdata  <= mp_rdata;
                            if_rvalid <= 1'b1;
                        end
                    end else if (wd_expired) begin
                        mp_req      <= 1'b0;
                        timeout_err <= 1'b1;
                        state       <= ARB_IDLE;
                    end
                end
                ARB_BUSY_MEM: begin
                    if (mp_ack) begin
                        mp_req   <= 1'b0;
                        state    <= ARB_IDLE;
                        mem_done <= 1'b1;
                        if (!mp_we)
                            mem_rdata <= mp_rdata;
                    end else if (wd_expired) begin
                        mp_req      <= 1'b0;
                        timeout_err <= 1'b1;
                        state       <= ARB_IDLE;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a simple memory responder and grant monitor.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, flush, mem_req, mem_we, mp_ack;
    logic [31:0] if_addr, mem_addr, mem_wdata, mp_rdata;
    logic [3:0]  mem_be;
    logic [31:0] if_rdata, mem_rdata, mp_addr, mp_wdata;
    logic        if_rvalid, if_stall, mem_done, mem_stall;
    logic        mp_req, mp_we, timeout_err;
    logic [3:0]  mp_be;

    int n_checks = 0;
    int n_fail   = 0;

    logic        ack_en = 1'b0;
    logic        req_q  = 1'b0;
    logic [31:0] grants[$];

    mem_port_arbiter #(.XLEN(32), .MAX_MEM_STREAK(4), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_rvalid(if_rvalid),
        .if_stall(if_stall), .flush(flush),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done), .mem_stall(mem_stall),
        .mp_req(mp_req), .mp_we(mp_we), .mp_be(mp_be), .mp_addr(mp_addr), .mp_wdata(mp_wdata),
        .mp_ack(mp_ack), .mp_rdata(mp_rdata), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Memory acks in the first cycle of a request; read data is the address XOR a fixed tag.
    always @(negedge clk) begin
        mp_ack   = ack_en && mp_req;
        mp_rdata = mp_addr ^ 32'hA5A5_0000;
    end

    always @(negedge clk) begin
        if (mp_req && !req_q)
            grants.push_back(mp_addr);
        req_q = mp_req;
    end

    task automatic test_reset();
        rst = 1'b1; if_req = 1'b0; flush = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
        mem_be = 4'h0; if_addr = '0; mem_addr = '0; mem_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (mp_req !== 1'b0) begin n_fail++; $display("FAIL reset_mp_req got %b want 0", mp_req); end
        n_checks++; if (mp_addr !== 32'h0) begin n_fail++; $display("FAIL reset_mp_addr got %h want 0", mp_addr); end
        n_checks++; if (mp_be !== 4'h0) begin n_fail++; $display("FAIL reset_mp_be got %h want 0", mp_be); end
        n_checks++; if ({if_rvalid, mem_done, timeout_err} !== 3'b000) begin n_fail++; $display("FAIL reset_pulses got %b want 000", {if_rvalid, mem_done, timeout_err}); end
        n_checks++; if ({if_rdata, mem_rdata} !== 64'h0) begin n_fail++; $display("FAIL reset_rdata got %h want 0", {if_rdata, mem_rdata}); end
        rst = 1'b0;
    endtask

    task automatic test_lone_if();
        ack_en = 1'b1; if_addr = 32'h10; if_req = 1'b1;
        @(negedge clk);
        n_checks++; if (mp_req !== 1'b1) begin n_fail++; $display("FAIL lone_if_mp_req got %b want 1", mp_req); end
        n_checks++; if (mp_addr !== 32'h10) begin n_fail++; $display("FAIL lone_if_addr got %h want 10", mp_addr); end
        n_checks++; if ({mp_we, mp_be} !== 5'b0_1111) begin n_fail++; $display("FAIL lone_if_we_be got %b want 01111", {mp_we, mp_be}); end
        n_checks++; if ({if_rvalid, if_stall} !== 2'b01) begin n_fail++; $display("FAIL lone_if_early got %b want 01", {if_rvalid, if_stall}); end
        @(negedge clk);
        n_checks++; if ({if_rvalid, if_stall} !== 2'b10) begin n_fail++; $display("FAIL lone_if_rvalid got %b want 10", {if_rvalid, if_stall}); end
        n_checks++; if (if_rdata !== 32'hA5A5_0010) begin n_fail++; $display("FAIL lone_if_rdata got %h want a5a50010", if_rdata); end
        if_req = 1'b0;
        @(negedge clk);
        n_checks++; if ({if_rvalid, mp_req} !== 2'b00) begin n_fail++; $display("FAIL lone_if_after got %b want 00", {if_rvalid, mp_req}); end
    endtask

    task automatic test_mem_priority();
        ack_en = 1'b1;
        mem_req = 1'b1; mem_we = 1'b1; mem_be = 4'b0011; mem_addr = 32'h200; mem_wdata = 32'hDEADBEEF;
        if_req = 1'b1; if_addr = 32'h30;
        @(negedge clk);
        n_checks++; if ({mp_req, mp_we, mp_be} !== 6'b1_1_0011) begin n_fail++; $display("FAIL prio_store_ctl got %b want 110011", {mp_req, mp_we, mp_be}); end
        n_checks++; if (mp_addr !== 32'h200) begin n_fail++; $display("FAIL prio_store_addr got %h want 200", mp_addr); end
        n_checks++; if (mp_wdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL prio_store_wdata got %h want deadbeef", mp_wdata); end
        @(negedge clk);
        n_checks++; if ({mem_done, if_rvalid, mem_stall} !== 3'b100) begin n_fail++; $display("FAIL prio_store_done got %b want 100", {mem_done, if_rvalid, mem_stall}); end
        n_checks++; if (mem_rdata !== 32'h0) begin n_fail++; $display("FAIL prio_store_rdata got %h want 0", mem_rdata); end
        mem_req = 1'b0; mem_we = 1'b0;
        @(negedge clk);
        n_checks++; if ({mp_req, mp_we, mp_be} !== 6'b1_0_1111 || mp_addr !== 32'h30) begin n_fail++; $display("FAIL prio_if_second got %b/%h want 101111/30", {mp_req, mp_we, mp_be}, mp_addr); end
        @(negedge clk);
        n_checks++; if (if_rvalid !== 1'b1 || if_rdata !== 32'hA5A5_0030) begin n_fail++; $display("FAIL prio_if_data got %b/%h want 1/a5a50030", if_rvalid, if_rdata); end
        if_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_streak();
        logic [31:0] exp_g[7];
        int done_cnt = 0;
        exp_g = '{32'h300, 32'h300, 32'h300, 32'h300, 32'h20, 32'h300, 32'h300};
        ack_en = 1'b1;
        grants.delete();
        mem_req = 1'b1; mem_we = 1'b0; mem_be = 4'hF; mem_addr = 32'h300;
        if_req = 1'b1; if_addr = 32'h20;
        for (int c = 0; c < 60 && (mem_req || if_req); c++) begin
            @(negedge clk);
            if (mem_done) begin
                done_cnt++;
                if (done_cnt == 6) mem_req = 1'b0;
            end
            if (if_rvalid) if_req = 1'b0;
        end
        n_checks++; if (mem_req || if_req) begin n_fail++; $display("FAIL streak_bound got reqs %b%b still pending want 00", mem_req, if_req); end
        mem_req = 1'b0; if_req = 1'b0;
        @(negedge clk);
        n_checks++; if (grants.size() != 7) begin n_fail++; $display("FAIL streak_grant_count got %0d want 7", grants.size()); end
        for (int i = 0; i < 7 && i < grants.size(); i++) begin
            n_checks++;
            if (grants[i] !== exp_g[i]) begin n_fail++; $display("FAIL streak_grant%0d got %h want %h", i, grants[i], exp_g[i]); end
        end
        n_checks++; if (mem_rdata !== 32'hA5A5_0300) begin n_fail++; $display("FAIL streak_load_rdata got %h want a5a50300", mem_rdata); end
    endtask

    task automatic test_flush();
        ack_en = 1'b1; flush = 1'b0; if_addr = 32'h80; if_req = 1'b1;
        @(negedge clk);
        n_checks++; if (mp_req !== 1'b1 || mp_addr !== 32'h80) begin n_fail++; $display("FAIL flush_grant got %b/%h want 1/80", mp_req, mp_addr); end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        n_checks++; if ({if_rvalid, if_stall, mp_req} !== 3'b010) begin n_fail++; $display("FAIL flush_suppress got %b want 010", {if_rvalid, if_stall, mp_req}); end
        if_addr = 32'h84;
        @(negedge clk);
        n_checks++; if (mp_req !== 1'b1 || mp_addr !== 32'h84) begin n_fail++; $display("FAIL flush_refetch got %b/%h want 1/84", mp_req, mp_addr); end
        @(negedge clk);
        n_checks++; if (if_rvalid !== 1'b1 || if_rdata !== 32'hA5A5_0084) begin n_fail++; $display("FAIL flush_refetch_data got %b/%h want 1/a5a50084", if_rvalid, if_rdata); end
        if_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int hi = 0;
        logic got = 1'b0, seen_rv = 1'b0;
        ack_en = 1'b0; if_addr = 32'h40; if_req = 1'b1;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            if (timeout_err) got = 1'b1;
            else if (mp_req) hi++;
            if (if_rvalid) seen_rv = 1'b1;
        end
        n_checks++; if (got !== 1'b1) begin n_fail++; $display("FAIL timeout_pulse got %b want 1", got); end
        n_checks++; if (hi != 16) begin n_fail++; $display("FAIL timeout_len got %0d want 16", hi); end
        n_checks++; if ({mp_req, seen_rv} !== 2'b00) begin n_fail++; $display("FAIL timeout_abort got %b want 00", {mp_req, seen_rv}); end
        ack_en = 1'b1;
        @(negedge clk);
        n_checks++; if ({mp_req, timeout_err} !== 2'b10 || mp_addr !== 32'h40) begin n_fail++; $display("FAIL timeout_retry got %b/%h want 10/40", {mp_req, timeout_err}, mp_addr); end
        @(negedge clk);
        n_checks++; if (if_rvalid !== 1'b1 || if_rdata !== 32'hA5A5_0040) begin n_fail++; $display("FAIL timeout_retry_data got %b/%h want 1/a5a50040", if_rvalid, if_rdata); end
        if_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic seen_done = 1'b0;
        ack_en = 1'b0; mem_req = 1'b1; mem_we = 1'b0; mem_be = 4'hF; mem_addr = 32'h500;
        @(negedge clk);
        n_checks++; if (mp_req !== 1'b1 || mp_addr !== 32'h500) begin n_fail++; $display("FAIL rstmid_busy got %b/%h want 1/500", mp_req, mp_addr); end
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if ({mp_req, mp_we, mp_be} !== 6'b0) begin n_fail++; $display("FAIL rstmid_ctl got %b want 000000", {mp_req, mp_we, mp_be}); end
        n_checks++; if ({mp_addr, mem_rdata, if_rdata} !== 96'h0) begin n_fail++; $display("FAIL rstmid_data got %h want 0", {mp_addr, mem_rdata, if_rdata}); end
        mem_req = 1'b0; rst = 1'b0; ack_en = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (mem_done || mp_req) seen_done = 1'b1;
        end
        n_checks++; if (seen_done !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_done got %b want 0", seen_done); end
    endtask

    initial begin
        test_reset();
        test_lone_if();
        test_mem_priority();
        test_streak();
        test_flush();
        test_timeout();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
